// File: rtl/est_loop_ctrl.sv
// Sequencer for the closed-loop delay estimator: picks delay polarity, gates the
// TOF counter, forwards measurements, handles W loading, timeouts and the estimate.
module est_loop_ctrl #(
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned HOLD_MIN  = 2,
  parameter logic [3:0]  W_DEFAULT = 4'd8
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic       l_r,
  input  logic [3:0] W_ext,
  input  logic       X1_sync,
  input  logic       X2_sync,
  input  logic       tof_ready,
  input  logic [7:0] tof_count,
  input  logic       est_ready,
  input  logic [7:0] est_data,
  output logic       input_sel,
  output logic       tof_en,
  output logic [7:0] z_out,
  output logic       z_valid,
  output logic [3:0] W_cfg,
  output logic       w_load,
  output logic [7:0] Y_output,
  output logic       lag_sign,
  output logic       data_ready,
  output logic       timeout_err
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ARM      = 3'd1;
  localparam logic [2:0] MEASURE  = 3'd2;
  localparam logic [2:0] WAIT_EST = 3'd3;
  localparam logic [2:0] LOAD     = 3'd4;

  logic [2:0] state, state_next;
  logic [7:0] timer;
  logic       lr_s1, lr_s2, lr_q;
  logic [7:0] lr_cnt;
  logic       x1_prev, x2_prev;
  logic       x1_rise, x2_rise;
  logic       timer_exp;
  logic       fire_z, fire_y, tmo;
  logic       load_entry;

  // l_r pad: two-flop synchronizer, then accept a new level only after it has
  // differed from lr_q for HOLD_MIN consecutive cycles.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      lr_s1  <= 1'b0;
      lr_s2  <= 1'b0;
      lr_q   <= 1'b0;
      lr_cnt <= '0;
    end else begin
      lr_s1 <= l_r;
      lr_s2 <= lr_s1;
      if (lr_s2 == lr_q) begin
        lr_cnt <= '0;
      end else if (lr_cnt == 8'(HOLD_MIN - 1)) begin
        lr_q   <= lr_s2;
        lr_cnt <= '0;
      end else begin
        lr_cnt <= lr_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      x1_prev <= 1'b0;
      x2_prev <= 1'b0;
    end else begin
      x1_prev <= X1_sync;
      x2_prev <= X2_sync;
    end
  end

  assign x1_rise   = X1_sync & ~x1_prev;
  assign x2_rise   = X2_sync & ~x2_prev;
  assign timer_exp = (timer == 8'(TIMEOUT - 1));

  // Priority in every active state: lr_q, then the state's event, then timeout.
  always_comb begin
    state_next = state;
    fire_z     = 1'b0;
    fire_y     = 1'b0;
    tmo        = 1'b0;
    case (state)
      IDLE: state_next = lr_q ? LOAD : ARM;
      ARM: begin
        if (lr_q)                    state_next = LOAD;
        else if (x1_rise || x2_rise) state_next = MEASURE;
        else if (timer_exp)          tmo = 1'b1;
      end
      MEASURE: begin
        if (lr_q) begin
          state_next = LOAD;
        end else if (tof_ready) begin
          fire_z     = 1'b1;
          state_next = WAIT_EST;
        end else if (timer_exp) begin
          tmo        = 1'b1;
          state_next = ARM;
        end
      end
      WAIT_EST: begin
        if (lr_q) begin
          state_next = LOAD;
        end else if (est_ready) begin
          fire_y     = 1'b1;
          state_next = ARM;
        end else if (timer_exp) begin
          tmo        = 1'b1;
          state_next = ARM;
        end
      end
      LOAD: if (!lr_q) state_next = ARM;
      default: state_next = IDLE;
    endcase
  end

  assign load_entry = (state_next == LOAD) && (state != LOAD);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state       <= IDLE;
      timer       <= '0;
      input_sel   <= 1'b0;
      tof_en      <= 1'b0;
      z_out       <= '0;
      z_valid     <= 1'b0;
      W_cfg       <= W_DEFAULT;
      w_load      <= 1'b0;
      Y_output    <= '0;
      lag_sign    <= 1'b0;
      data_ready  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_next;
      // A timeout in ARM re-enters ARM, so it restarts the timer like any entry.
      if ((state_next != state) || tmo)
        timer <= '0;
      else if (state == ARM || state == MEASURE || state == WAIT_EST)
        timer <= timer + 8'd1;

      if (state == ARM && state_next == MEASURE)
        input_sel <= ~x1_rise;
      tof_en <= (state_next == MEASURE);

      z_valid <= fire_z;
      if (fire_z)
        z_out <= tof_count;

      data_ready <= fire_y;
      if (fire_y) begin
        Y_output <= est_data;
        lag_sign <= input_sel;
      end

      w_load <= load_entry;
      if (load_entry) begin
        W_cfg       <= W_ext;
        timeout_err <= 1'b0;
      end else if (tmo) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_est_loop_ctrl.sv
// Bench for est_loop_ctrl: directed scenarios plus a random phase, every output
// compared each cycle against a transaction-level reference model.
module tb_est_loop_ctrl;
  localparam int TIMEOUT  = 255;
  localparam int HOLD_MIN = 2;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       l_r;
  logic [3:0] W_ext;
  logic       X1_sync, X2_sync;
  logic       tof_ready, est_ready;
  logic [7:0] tof_count, est_data;
  logic       input_sel, tof_en, z_valid, w_load, lag_sign, data_ready, timeout_err;
  logic [7:0] z_out, Y_output;
  logic [3:0] W_cfg;

  int n_tests = 0;
  int n_fail  = 0;

  est_loop_ctrl dut (
    .clk(clk), .reset_L(reset_L), .l_r(l_r), .W_ext(W_ext),
    .X1_sync(X1_sync), .X2_sync(X2_sync),
    .tof_ready(tof_ready), .tof_count(tof_count),
    .est_ready(est_ready), .est_data(est_data),
    .input_sel(input_sel), .tof_en(tof_en), .z_out(z_out), .z_valid(z_valid),
    .W_cfg(W_cfg), .w_load(w_load), .Y_output(Y_output), .lag_sign(lag_sign),
    .data_ready(data_ready), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Reference model: phase of the measurement cycle plus the expected outputs.
  typedef enum {M_IDLE, M_ARM, M_MEAS, M_WAIT, M_LOAD} mphase_t;
  mphase_t    m_ph;
  logic       lr_hist [0:15];
  logic       m_lrq, m_x1p, m_x2p;
  int         cyc, m_entry;
  logic       e_sel, e_tof_en, e_zv, e_wl, e_lag, e_dr, e_terr;
  logic [7:0] e_z, e_y;
  logic [3:0] e_w;

  task automatic model_reset();
    m_ph = M_IDLE;
    for (int i = 0; i < 16; i++) lr_hist[i] = 1'b0;
    m_lrq = 0; m_x1p = 0; m_x2p = 0;
    cyc = 0; m_entry = 0;
    e_sel = 0; e_tof_en = 0; e_zv = 0; e_wl = 0; e_lag = 0; e_dr = 0; e_terr = 0;
    e_z = 0; e_y = 0; e_w = 4'd8;
  endtask

  task automatic model_edge();
    mphase_t nxt;
    logic r1, r2, expired, tmo, agree;
    cyc++;
    r1 = X1_sync & ~m_x1p;
    r2 = X2_sync & ~m_x2p;
    expired = ((cyc - m_entry) == TIMEOUT);
    nxt = m_ph; tmo = 0;
    e_zv = 0; e_dr = 0; e_wl = 0;
    case (m_ph)
      M_IDLE: nxt = m_lrq ? M_LOAD : M_ARM;
      M_ARM:
        if (m_lrq) nxt = M_LOAD;
        else if (r1 || r2) begin e_sel = r1 ? 1'b0 : 1'b1; nxt = M_MEAS; end
        else if (expired) begin tmo = 1; e_terr = 1; end
      M_MEAS:
        if (m_lrq) nxt = M_LOAD;
        else if (tof_ready) begin e_z = tof_count; e_zv = 1; nxt = M_WAIT; end
        else if (expired) begin tmo = 1; e_terr = 1; nxt = M_ARM; end
      M_WAIT:
        if (m_lrq) nxt = M_LOAD;
        else if (est_ready) begin e_y = est_data; e_lag = e_sel; e_dr = 1; nxt = M_ARM; end
        else if (expired) begin tmo = 1; e_terr = 1; nxt = M_ARM; end
      M_LOAD: if (!m_lrq) nxt = M_ARM;
      default: nxt = M_IDLE;
    endcase
    if (nxt == M_LOAD && m_ph != M_LOAD) begin e_wl = 1; e_w = W_ext; e_terr = 0; end
    if (nxt != m_ph || tmo) m_entry = cyc;
    m_ph = nxt;
    e_tof_en = (nxt == M_MEAS);
    // l_r reaches the qualifier two edges late; a level is accepted once
    // HOLD_MIN consecutive delayed samples agree on it.
    for (int i = 15; i > 0; i--) lr_hist[i] = lr_hist[i-1];
    lr_hist[0] = l_r;
    agree = 1'b1;
    for (int i = 2; i < 2 + HOLD_MIN; i++)
      if (lr_hist[i] != lr_hist[2]) agree = 1'b0;
    if (agree) m_lrq = lr_hist[2];
    m_x1p = X1_sync; m_x2p = X2_sync;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_all(input string p);
    chk({p, ".input_sel"},   {7'd0, input_sel},   {7'd0, e_sel});
    chk({p, ".tof_en"},      {7'd0, tof_en},      {7'd0, e_tof_en});
    chk({p, ".z_out"},       z_out,               e_z);
    chk({p, ".z_valid"},     {7'd0, z_valid},     {7'd0, e_zv});
    chk({p, ".W_cfg"},       {4'd0, W_cfg},       {4'd0, e_w});
    chk({p, ".w_load"},      {7'd0, w_load},      {7'd0, e_wl});
    chk({p, ".Y_output"},    Y_output,            e_y);
    chk({p, ".lag_sign"},    {7'd0, lag_sign},    {7'd0, e_lag});
    chk({p, ".data_ready"},  {7'd0, data_ready},  {7'd0, e_dr});
    chk({p, ".timeout_err"}, {7'd0, timeout_err}, {7'd0, e_terr});
  endtask

  task automatic step(input string p, input logic lr, input logic [3:0] w,
                      input logic x1, input logic x2, input logic tr,
                      input logic [7:0] tc, input logic er, input logic [7:0] ed);
    l_r = lr; W_ext = w; X1_sync = x1; X2_sync = x2;
    tof_ready = tr; tof_count = tc; est_ready = er; est_data = ed;
    model_edge();
    @(posedge clk);
    #1;
    check_all(p);
  endtask

  task automatic idle(input string p, input int n, input logic x1, input logic x2);
    for (int i = 0; i < n; i++) step(p, 1'b0, 4'h0, x1, x2, 1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  initial begin
    logic lr_lvl;
    logic x1r, x2r;
    logic [3:0] wr;
    reset_L = 1'b0;
    l_r = 0; W_ext = 0; X1_sync = 0; X2_sync = 0;
    tof_ready = 0; tof_count = 0; est_ready = 0; est_data = 0;
    model_reset();

    // Reset held for three cycles.
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    reset_L = 1'b1;
    idle("post_reset", 3, 0, 0);
    $display("[TB] reset phase complete");

    // Qualified load of W=5.
    for (int i = 0; i < 6; i++) step("load", 1'b1, 4'h5, 0, 0, 0, 8'h00, 0, 8'h00);
    idle("load_exit", 8, 0, 0);
    chk("load.W_cfg_final", {4'd0, W_cfg}, 8'h05);
    $display("[TB] load W=5 transaction complete");

    // Single-cycle l_r glitch must not load.
    step("glitch", 1'b1, 4'h3, 0, 0, 0, 8'h00, 0, 8'h00);
    idle("glitch_after", 6, 0, 0);
    chk("glitch.W_cfg_kept", {4'd0, W_cfg}, 8'h05);
    $display("[TB] l_r glitch transaction complete");

    // X2 leads X1 by three cycles, then a measurement and an estimate.
    step("pol", 0, 0, 0, 1, 0, 8'h00, 0, 8'h00);
    idle("pol", 2, 0, 1);
    step("pol", 0, 0, 1, 1, 0, 8'h00, 0, 8'h00);
    idle("pol", 2, 1, 1);
    step("pol_tof", 0, 0, 1, 1, 1, 8'h2A, 0, 8'h00);
    chk("pol.z_out", z_out, 8'h2A);
    chk("pol.input_sel", {7'd0, input_sel}, 8'h01);
    idle("pol", 2, 1, 1);
    step("pol_est", 0, 0, 1, 1, 0, 8'h00, 1, 8'h27);
    chk("pol.Y_output", Y_output, 8'h27);
    chk("pol.lag_sign", {7'd0, lag_sign}, 8'h01);
    idle("pol_tail", 3, 0, 0);
    $display("[TB] X2-leads measurement transaction complete");

    // Timeout in MEASURE, then a load clears the flag.
    step("tmo_arm", 0, 0, 1, 0, 0, 8'h00, 0, 8'h00);
    idle("tmo", TIMEOUT, 1, 0);
    chk("tmo.timeout_err", {7'd0, timeout_err}, 8'h01);
    chk("tmo.tof_en", {7'd0, tof_en}, 8'h00);
    idle("tmo_after", 3, 0, 0);
    for (int i = 0; i < 6; i++) step("tmo_load", 1'b1, 4'hA, 0, 0, 0, 8'h00, 0, 8'h00);
    chk("tmo.cleared", {7'd0, timeout_err}, 8'h00);
    idle("tmo_load_exit", 8, 0, 0);
    $display("[TB] timeout transaction complete");

    // Simultaneous rise picks X1; then est_ready collides with the lr_q rise.
    step("both", 0, 0, 1, 1, 0, 8'h00, 0, 8'h00);
    chk("both.input_sel", {7'd0, input_sel}, 8'h00);
    step("both_tof", 0, 0, 1, 1, 1, 8'h11, 0, 8'h00);
    for (int i = 0; i < 4; i++) step("coll", 1'b1, 4'h6, 1, 1, 0, 8'h00, 0, 8'h00);
    step("coll_est", 1'b1, 4'h6, 1, 1, 0, 8'h00, 1, 8'h99);
    chk("coll.data_ready", {7'd0, data_ready}, 8'h00);
    chk("coll.w_load", {7'd0, w_load}, 8'h01);
    chk("coll.Y_output", Y_output, 8'h27);
    idle("coll_exit", 8, 0, 0);
    $display("[TB] collision transactions complete");

    // Random traffic against the model.
    lr_lvl = 1'b0; wr = 4'h0; x1r = 0; x2r = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) lr_lvl = ~lr_lvl;
      if (!lr_lvl) wr = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) x1r = ~x1r;
      if ($urandom_range(0, 5) == 0) x2r = ~x2r;
      step("rand", lr_lvl ^ ($urandom_range(0, 29) == 0), wr, x1r, x2r,
           ($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)),
           ($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)));
    end
    idle("rand_tail", 10, 0, 0);
    $display("[TB] random phase complete");

    // Asynchronous reset while measuring.
    step("mid", 0, 0, 1, 0, 0, 8'h00, 0, 8'h00);
    chk("mid.tof_en_before", {7'd0, tof_en}, 8'h01);
    #2;
    reset_L = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    @(posedge clk);
    #1;
    reset_L = 1'b1;
    idle("post_async", 4, 0, 0);
    $display("[TB] async reset transaction complete");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
